// File: rtl/tournament_bp.sv
// Tournament branch predictor: gshare + two-level local with per-branch chooser and typed BTB.
// Define RAS_EN to add a circular return-address stack for return targets.
module tournament_bp #(
    parameter int PC_LENGTH = 32,
    parameter int GHR_BITS  = 10,
    parameter int LHT_INDEX = 6,
    parameter int LHR_BITS  = 8,
    parameter int BTB_INDEX = 6,
    parameter int RAS_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PC_LENGTH-1:0] i_pc_in,
    input  logic                 i_fetch_valid,
    input  logic                 i_update,
    input  logic                 i_taken,
    input  logic [PC_LENGTH-1:0] i_pc_ex,
    input  logic [PC_LENGTH-1:0] i_target_pc,
    input  logic [1:0]           i_br_type,
    output logic                 o_pc_sel,
    output logic [PC_LENGTH-1:0] o_target_predict,
    output logic                 o_predict_bit_BP,
    output logic                 o_chooser_sel
);
    localparam int GSZ     = 1 << GHR_BITS;
    localparam int LHT_SZ  = 1 << LHT_INDEX;
    localparam int LPHT_SZ = 1 << LHR_BITS;
    localparam int BTB_SZ  = 1 << BTB_INDEX;
    localparam int TAG_W   = PC_LENGTH - BTB_INDEX - 2;

    localparam logic [1:0] BR_COND = 2'b00;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        else    return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    logic [GSZ-1:0][1:0]              r_gpht;
    logic [GSZ-1:0][1:0]              r_chooser;
    logic [GHR_BITS-1:0]              r_ghr;
    logic [LHT_SZ-1:0][LHR_BITS-1:0]  r_lht;
    logic [LPHT_SZ-1:0][1:0]          r_lpht;
    logic [BTB_SZ-1:0]                r_btb_valid;
    logic [BTB_SZ-1:0][TAG_W-1:0]     r_btb_tag;
    logic [BTB_SZ-1:0][PC_LENGTH-1:0] r_btb_tgt;
    logic [BTB_SZ-1:0][1:0]           r_btb_type;

    // Fetch-side lookup
    logic [GHR_BITS-1:0]  w_f_cidx, w_f_gidx;
    logic [LHT_INDEX-1:0] w_f_lidx;
    logic [LHR_BITS-1:0]  w_f_lhr;
    logic [BTB_INDEX-1:0] w_f_bidx;
    logic [TAG_W-1:0]     w_f_tag;
    logic [1:0]           w_f_type;
    logic                 w_f_hit;

    assign w_f_cidx = i_pc_in[GHR_BITS+1:2];
    assign w_f_gidx = w_f_cidx ^ r_ghr;
    assign w_f_lidx = i_pc_in[LHT_INDEX+1:2];
    assign w_f_lhr  = r_lht[w_f_lidx];
    assign w_f_bidx = i_pc_in[BTB_INDEX+1:2];
    assign w_f_tag  = i_pc_in[PC_LENGTH-1:BTB_INDEX+2];
    assign w_f_hit  = r_btb_valid[w_f_bidx] && (r_btb_tag[w_f_bidx] == w_f_tag);
    assign w_f_type = r_btb_type[w_f_bidx];

    assign o_chooser_sel    = r_chooser[w_f_cidx][1];
    assign o_predict_bit_BP = o_chooser_sel ? r_gpht[w_f_gidx][1] : r_lpht[w_f_lhr][1];
    assign o_pc_sel         = w_f_hit && ((w_f_type != BR_COND) || o_predict_bit_BP);

    // Resolve-side indices. The gshare counter trained is the one the next fetch
    // will read (history already including this outcome); the chooser compares
    // against what fetch would have predicted with the pre-update history.
    logic [GHR_BITS-1:0]  w_e_cidx, w_e_gidx_old, w_e_gidx_new, w_ghr_next;
    logic [LHT_INDEX-1:0] w_e_lidx;
    logic [LHR_BITS-1:0]  w_e_lhr;
    logic [BTB_INDEX-1:0] w_e_bidx;
    logic                 w_e_gpred, w_e_lpred;

    assign w_ghr_next   = {r_ghr[GHR_BITS-2:0], i_taken};
    assign w_e_cidx     = i_pc_ex[GHR_BITS+1:2];
    assign w_e_gidx_old = w_e_cidx ^ r_ghr;
    assign w_e_gidx_new = w_e_cidx ^ w_ghr_next;
    assign w_e_lidx     = i_pc_ex[LHT_INDEX+1:2];
    assign w_e_lhr      = r_lht[w_e_lidx];
    assign w_e_bidx     = i_pc_ex[BTB_INDEX+1:2];
    assign w_e_gpred    = r_gpht[w_e_gidx_old][1];
    assign w_e_lpred    = r_lpht[w_e_lhr][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpht    <= {GSZ{2'b01}};
            r_chooser <= {GSZ{2'b10}};
            r_ghr     <= '0;
            r_lht     <= '0;
            r_lpht    <= {LPHT_SZ{2'b01}};
        end else if (i_update) begin
            r_ghr                <= w_ghr_next;
            r_gpht[w_e_gidx_new] <= sat2(r_gpht[w_e_gidx_new], i_taken);
            r_lpht[w_e_lhr]      <= sat2(r_lpht[w_e_lhr], i_taken);
            r_lht[w_e_lidx]      <= {w_e_lhr[LHR_BITS-2:0], i_taken};
            if (w_e_gpred != w_e_lpred)
                r_chooser[w_e_cidx] <= sat2(r_chooser[w_e_cidx], w_e_gpred == i_taken);
        end
    end

    // BTB only allocates on taken outcomes; not-taken leaves entries intact
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btb_valid <= '0;
            r_btb_tag   <= '0;
            r_btb_tgt   <= '0;
            r_btb_type  <= '0;
        end else if (i_update && i_taken) begin
            r_btb_valid[w_e_bidx] <= 1'b1;
            r_btb_tag[w_e_bidx]   <= i_pc_ex[PC_LENGTH-1:BTB_INDEX+2];
            r_btb_tgt[w_e_bidx]   <= i_target_pc;
            r_btb_type[w_e_bidx]  <= i_br_type;
        end
    end

`ifdef RAS_EN
    localparam int         RP_W     = $clog2(RAS_DEPTH);
    localparam int         RC_W     = RP_W + 1;
    localparam logic [1:0] BR_CALL  = 2'b10;
    localparam logic [1:0] BR_RET   = 2'b11;
    localparam logic [RC_W-1:0] RAS_FULL = RC_W'(RAS_DEPTH);

    logic [RAS_DEPTH-1:0][PC_LENGTH-1:0] r_ras;
    logic [RP_W-1:0]                     r_ras_ptr;
    logic [RC_W-1:0]                     r_ras_cnt;
    logic [RP_W-1:0]                     w_ras_top;
    logic                                w_ras_ret, w_push, w_pop;
    logic                                w_unused;

    assign w_ras_top = r_ras_ptr - RP_W'(1);
    assign w_ras_ret = w_f_hit && (w_f_type == BR_RET) && (r_ras_cnt != '0);
    assign w_push    = i_fetch_valid && w_f_hit && (w_f_type == BR_CALL);
    assign w_pop     = i_fetch_valid && w_ras_ret;
    assign o_target_predict = w_ras_ret ? r_ras[w_ras_top] : r_btb_tgt[w_f_bidx];
    assign w_unused  = ^i_pc_ex[1:0];

    // Pointer wraps on overflow so the oldest return address is overwritten
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_push) begin
            r_ras[r_ras_ptr] <= i_pc_in + PC_LENGTH'(4);
            r_ras_ptr        <= r_ras_ptr + RP_W'(1);
            if (r_ras_cnt != RAS_FULL) r_ras_cnt <= r_ras_cnt + RC_W'(1);
        end else if (w_pop) begin
            r_ras_ptr <= w_ras_top;
            r_ras_cnt <= r_ras_cnt - RC_W'(1);
        end
    end
`else
    logic w_unused;
    assign o_target_predict = r_btb_tgt[w_f_bidx];
    assign w_unused = ^{i_pc_in[1:0], i_pc_ex[1:0], i_fetch_valid} ^ (RAS_DEPTH == 0);
`endif

endmodule

// File: tb/tb_tournament_bp.sv
// Directed bench for tournament_bp: reset, learning, chooser, aliasing, sync reset, return targets.
// Return-stack scenarios are exercised when RAS_EN is defined, BTB-only returns otherwise.
module tb_tournament_bp;
    localparam int PCW = 32;
    localparam int BTBI = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [PCW-1:0] i_pc_in;
    logic           i_fetch_valid;
    logic           i_update;
    logic           i_taken;
    logic [PCW-1:0] i_pc_ex;
    logic [PCW-1:0] i_target_pc;
    logic [1:0]     i_br_type;
    logic           o_pc_sel;
    logic [PCW-1:0] o_target_predict;
    logic           o_predict_bit_BP;
    logic           o_chooser_sel;

    int tests = 0;
    int fails = 0;

    tournament_bp #(
        .PC_LENGTH(PCW), .GHR_BITS(10), .LHT_INDEX(6), .LHR_BITS(8),
        .BTB_INDEX(BTBI), .RAS_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .i_pc_in(i_pc_in), .i_fetch_valid(i_fetch_valid),
        .i_update(i_update), .i_taken(i_taken), .i_pc_ex(i_pc_ex),
        .i_target_pc(i_target_pc), .i_br_type(i_br_type), .o_pc_sel(o_pc_sel),
        .o_target_predict(o_target_predict), .o_predict_bit_BP(o_predict_bit_BP),
        .o_chooser_sel(o_chooser_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_update = 1'b0; i_fetch_valid = 1'b0;
        next();
        rst = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic tk,
                             input logic [31:0] tgt, input logic [1:0] ty);
        i_update = 1'b1; i_pc_ex = pc; i_taken = tk; i_target_pc = tgt; i_br_type = ty;
        next();
        i_update = 1'b0;
    endtask

    // Present a fetch PC and wait to the sampling point (negedge)
    task automatic fetch(input logic [31:0] pc, input logic fv);
        i_pc_in = pc; i_fetch_valid = fv;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; i_pc_in = '0; i_fetch_valid = 1'b0; i_update = 1'b0;
        i_taken = 1'b0; i_pc_ex = '0; i_target_pc = '0; i_br_type = 2'b00;

        // Reset state
        do_reset();
        fetch(32'h100, 1'b0);
        chk("rst_pc_sel", o_pc_sel, 1'b0);
        chk("rst_chooser", o_chooser_sel, 1'b1);
        chk("rst_target", o_target_predict, 32'h0);
        chk("rst_predict", o_predict_bit_BP, 1'b0);
        fetch(32'hABC, 1'b0);
        chk("rst_pc_sel2", o_pc_sel, 1'b0);
        chk("rst_target2", o_target_predict, 32'h0);

        // Conditional learning; same-cycle fetch sees the old state
        next();
        i_pc_in = 32'h100;
        i_update = 1'b1; i_pc_ex = 32'h100; i_taken = 1'b1; i_target_pc = 32'h200; i_br_type = 2'b00;
        @(negedge clk);
        chk("nobypass_pc_sel", o_pc_sel, 1'b0);
        next();
        i_update = 1'b0;
        fetch(32'h100, 1'b0);
        chk("learn_pc_sel", o_pc_sel, 1'b1);
        chk("learn_target", o_target_predict, 32'h200);
        chk("learn_predict", o_predict_bit_BP, 1'b1);
        chk("learn_chooser", o_chooser_sel, 1'b1);

        // Not-taken neither allocates nor invalidates
        next();
        do_update(32'h800, 1'b0, 32'h900, 2'b00);
        fetch(32'h800, 1'b0);
        chk("nt_noalloc_pc_sel", o_pc_sel, 1'b0);
        next();
        do_update(32'h600, 1'b1, 32'h700, 2'b01);
        do_update(32'h600, 1'b0, 32'h0, 2'b01);
        fetch(32'h600, 1'b0);
        chk("nt_keep_pc_sel", o_pc_sel, 1'b1);
        chk("nt_keep_target", o_target_predict, 32'h700);

        // Alternating T,N at 0x140: local wins, chooser goes to local
        next();
        do_reset();
        for (int k = 0; k < 40; k++) do_update(32'h140, (k % 2) == 0, 32'h180, 2'b00);
        fetch(32'h140, 1'b0);
        chk("alt_chooser", o_chooser_sel, 1'b0);
        chk("alt_predict_T", o_predict_bit_BP, 1'b1);
        chk("alt_pc_sel_T", o_pc_sel, 1'b1);
        chk("alt_target", o_target_predict, 32'h180);
        next();
        do_update(32'h140, 1'b1, 32'h180, 2'b00);
        fetch(32'h140, 1'b0);
        chk("alt_predict_N", o_predict_bit_BP, 1'b0);
        chk("alt_pc_sel_N", o_pc_sel, 1'b0);
        chk("alt_chooser2", o_chooser_sel, 1'b0);

        // BTB aliasing: 0x100 and 0x100 + 4*2^BTB_INDEX share an entry
        next();
        do_reset();
        do_update(32'h100, 1'b1, 32'h200, 2'b00);
        do_update(32'h100 + (32'd4 << BTBI), 1'b1, 32'h300, 2'b00);
        fetch(32'h100, 1'b0);
        chk("alias_old_pc_sel", o_pc_sel, 1'b0);
        fetch(32'h500, 1'b0);
        chk("alias_new_pc_sel", o_pc_sel, 1'b1);
        chk("alias_new_target", o_target_predict, 32'h300);

        // Reset mid-operation wins over a same-cycle update
        next();
        rst = 1'b1;
        i_update = 1'b1; i_pc_ex = 32'h900; i_taken = 1'b1; i_target_pc = 32'h990; i_br_type = 2'b01;
        next();
        rst = 1'b0; i_update = 1'b0;
        fetch(32'h500, 1'b0);
        chk("midrst_pc_sel", o_pc_sel, 1'b0);
        chk("midrst_target", o_target_predict, 32'h0);
        chk("midrst_chooser", o_chooser_sel, 1'b1);
        fetch(32'h900, 1'b0);
        chk("midrst_upd_ignored", o_pc_sel, 1'b0);

        next();
        do_reset();
        do_update(32'h300, 1'b1, 32'h1000, 2'b10);
        do_update(32'h400, 1'b1, 32'h2000, 2'b10);
        do_update(32'h500, 1'b1, 32'h0, 2'b11);
`ifdef RAS_EN
        fetch(32'h300, 1'b0);              // no push without fetch_valid
        next();
        fetch(32'h300, 1'b1);
        chk("ras_call1_target", o_target_predict, 32'h1000);
        next();
        fetch(32'h400, 1'b1);
        chk("ras_call2_target", o_target_predict, 32'h2000);
        next();
        fetch(32'h500, 1'b1);
        chk("ras_ret1_target", o_target_predict, 32'h404);
        chk("ras_ret1_pc_sel", o_pc_sel, 1'b1);
        next();
        fetch(32'h500, 1'b1);
        chk("ras_ret2_target", o_target_predict, 32'h304);
        next();
        fetch(32'h500, 1'b1);
        chk("ras_empty_target", o_target_predict, 32'h0);
        chk("ras_empty_pc_sel", o_pc_sel, 1'b1);
        next();

        // Overflow: 9 pushes, 8 pops return the newest 8 in reverse order
        i_fetch_valid = 1'b0;
        do_reset();
        for (int k = 0; k < 9; k++) do_update(32'h1000 + 32'(8 * k), 1'b1, 32'h4000, 2'b10);
        do_update(32'h2F00, 1'b1, 32'hDEAD0, 2'b11);
        for (int k = 0; k < 9; k++) begin
            fetch(32'h1000 + 32'(8 * k), 1'b1);
            next();
        end
        for (int k = 8; k >= 1; k--) begin
            fetch(32'h2F00, 1'b1);
            chk($sformatf("ovf_pop%0d", k), o_target_predict, 32'h1000 + 32'(8 * k) + 32'd4);
            next();
        end
        fetch(32'h2F00, 1'b1);
        chk("ovf_empty_target", o_target_predict, 32'hDEAD0);
        next();
        i_fetch_valid = 1'b0;
`else
        fetch(32'h300, 1'b1);
        chk("noras_call_target", o_target_predict, 32'h1000);
        chk("noras_call_pc_sel", o_pc_sel, 1'b1);
        next();
        fetch(32'h500, 1'b1);
        chk("noras_ret_target", o_target_predict, 32'h0);
        chk("noras_ret_pc_sel", o_pc_sel, 1'b1);
        next();
        i_fetch_valid = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
